// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder: FSM state encoding and
// the digit-step counter width.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int count_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder used for one serial step.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Serial a + b + cin, DIGIT bits per clock with a registered carry,
// using a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = count_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             c_reg;
    logic [CW-1:0]    count;

    logic [DIGIT-1:0] dsum;
    logic             dco;
    logic [WIDTH-1:0] s_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x  (a_reg[DIGIT-1:0]),
        .y  (b_reg[DIGIT-1:0]),
        .ci (c_reg),
        .s  (dsum),
        .co (dco)
    );

    // Each new digit enters at the top, so after N steps digit 0 sits at the bottom.
    if (DIGIT == WIDTH) begin : g_single_step
        assign s_next = dsum;
    end else begin : g_multi_step
        assign s_next = {dsum, s_reg[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            c_reg <= 1'b0;
            count <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        s_reg <= '0;
                        c_reg <= cin;
                        count <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    s_reg <= s_next;
                    c_reg <= dco;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        sum   <= s_next;
                        carry <= dco;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: one instance with DIGIT=1, one with DIGIT=4.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, cin1, busy1, done1, carry1;
    logic [7:0] a1, b1, sum1;
    logic       start4, cin4, busy4, done4, carry4;
    logic [7:0] a4, b4, sum4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] q1[$];
    logic [8:0] q4[$];
    logic [8:0] last1 = '0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b1;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy1, done1, carry1, sum1} !== 11'b0) begin
            bad++;
            $display("FAIL reset_d1 got busy=%b done=%b carry=%b sum=%h want 0 0 0 00", busy1, done1, carry1, sum1);
        end
        total++;
        if ({busy4, done4, carry4, sum4} !== 11'b0) begin
            bad++;
            $display("FAIL reset_d4 got busy=%b done=%b carry=%b sum=%h want 0 0 0 00", busy4, done4, carry4, sum4);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int t0, tdone, nbusy, ndone, both;
        logic [8:0] got, exp;
        @(posedge clk); #1;
        start1 = 1'b1; a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0;
        @(posedge clk); #1;
        t0 = cyc;
        start1 = 1'b0;
        q1.push_back(9'h000);
        nbusy = 0; ndone = 0; both = 0; tdone = -1; got = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy1) nbusy++;
            if (busy1 && done1) both++;
            if (done1) begin
                ndone++;
                if (tdone < 0) begin
                    tdone = cyc;
                    got = {carry1, sum1};
                end
            end
        end
        exp = q1.pop_front();
        last1 = exp;
        total++;
        if (nbusy != 8) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=8", nbusy); end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL zero_done_pulses got=%0d want=1", ndone); end
        total++;
        if (both != 0) begin bad++; $display("FAIL zero_busy_and_done got=%0d want=0", both); end
        total++;
        if (tdone - t0 != 8) begin bad++; $display("FAIL zero_latency got=%0d want=8", tdone - t0); end
        total++;
        if (got !== exp) begin bad++; $display("FAIL zero_result got=%h want=%h", got, exp); end
    endtask

    task automatic test_vectors();
        logic [16:0] tbl [3];
        logic [8:0]  exp;
        int k;
        tbl[0] = {8'hFF, 8'h01, 1'b0};
        tbl[1] = {8'hA5, 8'h5A, 1'b1};
        tbl[2] = {8'h3C, 8'h42, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            {a1, b1, cin1} = tbl[i];
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            q1.push_back(9'(tbl[i][16:9]) + 9'(tbl[i][8:1]) + 9'(tbl[i][0]));
            k = 0;
            do begin @(negedge clk); k++; end while (!done1 && k < 40);
            exp = q1.pop_front();
            last1 = exp;
            total++;
            if (!done1) begin
                bad++; $display("FAIL vec%0d_timeout got done=0 want done=1", i);
            end else if ({carry1, sum1} !== exp) begin
                bad++; $display("FAIL vec%0d_result got=%h want=%h", i, {carry1, sum1}, exp);
            end
        end
    endtask

    task automatic test_start_ignored();
        int holdbad;
        logic [8:0] exp;
        @(posedge clk); #1;
        start1 = 1'b1; a1 = 8'h10; b1 = 8'h20; cin1 = 1'b0;
        @(posedge clk); #1;
        q1.push_back(9'h030);
        holdbad = 0;
        for (int c = 1; c <= 8; c++) begin
            start1 = (c == 3);
            if (c == 3) begin a1 = 8'hFF; b1 = 8'hFF; end
            @(negedge clk);
            if (!busy1 || {carry1, sum1} !== last1) holdbad++;
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        total++;
        if (holdbad != 0) begin bad++; $display("FAIL ign_hold_during_run got=%0d bad cycles want=0", holdbad); end
        @(negedge clk);
        exp = q1.pop_front();
        last1 = exp;
        total++;
        if (!done1 || {carry1, sum1} !== exp) begin
            bad++; $display("FAIL ign_result got done=%b val=%h want done=1 val=%h", done1, {carry1, sum1}, exp);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (busy1 || done1) begin
            bad++; $display("FAIL ign_no_restart got busy=%b done=%b want 0 0", busy1, done1);
        end
    endtask

    task automatic test_reset_abort();
        int ndone, k;
        logic [8:0] exp;
        @(posedge clk); #1;
        start1 = 1'b1; a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q1.delete();
        last1 = '0;
        @(negedge clk);
        total++;
        if ({busy1, done1, carry1, sum1} !== 11'b0) begin
            bad++;
            $display("FAIL abort_state got busy=%b done=%b carry=%b sum=%h want 0 0 0 00", busy1, done1, carry1, sum1);
        end
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done1 || busy1) ndone++;
        end
        total++;
        if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d active cycles want=0", ndone); end
        @(posedge clk); #1;
        start1 = 1'b1; a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b0;
        q1.push_back(9'h100);
        k = 0;
        do begin @(negedge clk); k++; end while (!done1 && k < 40);
        exp = q1.pop_front();
        last1 = exp;
        total++;
        if (!done1 || {carry1, sum1} !== exp) begin
            bad++; $display("FAIL abort_restart got done=%b val=%h want done=1 val=%h", done1, {carry1, sum1}, exp);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, k;
        logic [8:0] exp;
        @(posedge clk); #1;
        start1 = 1'b1; a1 = 8'h01; b1 = 8'h02; cin1 = 1'b0;
        @(posedge clk); #1;
        q1.push_back(9'h003);
        a1 = 8'h80; b1 = 8'h80;
        q1.push_back(9'h100);
        k = 0;
        do begin @(negedge clk); k++; end while (!done1 && k < 40);
        t1 = cyc;
        exp = q1.pop_front();
        total++;
        if (!done1 || {carry1, sum1} !== exp) begin
            bad++; $display("FAIL b2b_first got done=%b val=%h want done=1 val=%h", done1, {carry1, sum1}, exp);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk);
        total++;
        if (!busy1 || done1) begin
            bad++; $display("FAIL b2b_rerun got busy=%b done=%b want 1 0", busy1, done1);
        end
        k = 0;
        do begin @(negedge clk); k++; end while (!done1 && k < 40);
        t2 = cyc;
        exp = q1.pop_front();
        last1 = exp;
        total++;
        if (!done1 || {carry1, sum1} !== exp) begin
            bad++; $display("FAIL b2b_second got done=%b val=%h want done=1 val=%h", done1, {carry1, sum1}, exp);
        end
        total++;
        if (t2 - t1 != 9) begin bad++; $display("FAIL b2b_spacing got=%0d want=9", t2 - t1); end
    endtask

    task automatic test_digit4();
        int t0, k;
        logic [8:0] exp;
        logic [7:0] ra, rb;
        logic       rc;
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 8'h9F; b4 = 8'h71; cin4 = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start4 = 1'b0;
        q4.push_back(9'h111);
        k = 0;
        do begin @(negedge clk); k++; end while (!done4 && k < 20);
        exp = q4.pop_front();
        total++;
        if (!done4 || {carry4, sum4} !== exp) begin
            bad++; $display("FAIL d4_result got done=%b val=%h want done=1 val=%h", done4, {carry4, sum4}, exp);
        end
        total++;
        if (cyc - t0 != 2) begin bad++; $display("FAIL d4_latency got=%0d want=2", cyc - t0); end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            @(posedge clk); #1;
            start4 = 1'b1; a4 = ra; b4 = rb; cin4 = rc;
            @(posedge clk); #1;
            start4 = 1'b0;
            a4 = 8'($urandom); b4 = 8'($urandom); cin4 = 1'($urandom);
            q4.push_back(9'(ra) + 9'(rb) + 9'(rc));
            k = 0;
            do begin @(negedge clk); k++; end while (!done4 && k < 20);
            exp = q4.pop_front();
            total++;
            if (!done4 || {carry4, sum4} !== exp) begin
                bad++;
                $display("FAIL sweep%0d a=%h b=%h cin=%b got done=%b val=%h want val=%h",
                         i, ra, rb, rc, done4, {carry4, sum4}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_vectors();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_digit4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
